ms_timer: RTL and testbench
===========================

Name: ms_timer

Overview:
- Millisecond up/down timer, the responder to the reaction-time controller's `reset`/`up`/`enable` command outputs.
- Divides `clk` down to a 1 ms tick and counts that tick up from 0 (reaction measurement) or down from a preloaded delay (random wait).
- Drives `timer_value` back to the controller and flags zero, saturation and overflow.

Parameters:
- MAX_MS, 2047: maximum count in ms; count width CW = $clog2(MAX_MS).
- CLKS_PER_MS, 50000: `clk` cycles per 1 ms tick. Must be ≥ 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- reset  input  1  synchronous timer clear/load command from the controller.
- up  input  1  direction: 1 = count up, 0 = count down.
- enable  input  1  1 = counting allowed, 0 = hold.
- preload  input  CW  delay value in ms, loaded on `reset` when `up`=0.
- timer_value  output  CW  current count in ms, registered.
- ms_tick  output  1  one-cycle pulse on each prescaler wrap.
- at_zero  output  1  combinational: `timer_value` == 0.
- at_max  output  1  combinational: `timer_value` == MAX_MS.
- overflow  output  1  sticky: an up-count was blocked at MAX_MS.

Behaviour:
- `rst` asserted (async):
  - `timer_value`=0, prescaler=0, `ms_tick`=0, `overflow`=0.
  - `at_zero`=1, `at_max`=0.
  - Takes effect immediately, including mid-count.
- Priority each `clk` edge: `rst` > `reset` > `enable` > hold.
- `reset`=1:
  - Prescaler <= 0; `ms_tick` <= 0; `overflow` <= 0.
  - `timer_value` <= (`up` ? 0 : min(`preload`, MAX_MS)).
  - `enable` is ignored in the same cycle.
- `reset`=0, `enable`=1:
  - Prescaler increments each cycle.
  - At prescaler == CLKS_PER_MS-1: prescaler <= 0 and `ms_tick` <= 1 for exactly one cycle.
  - On the same edge the count steps:
    - `up`=1 and `timer_value` < MAX_MS: +1.
    - `up`=1 and `timer_value` == MAX_MS: hold, `overflow` <= 1.
    - `up`=0 and `timer_value` > 0: -1.
    - `up`=0 and `timer_value` == 0: hold (saturate at 0, no wrap, no flag).
- `reset`=0, `enable`=0:
  - Prescaler, `timer_value` and `overflow` hold; `ms_tick` <= 0.
  - Re-enabling resumes mid-millisecond with no loss of partial count.
- Latency: first step occurs CLKS_PER_MS cycles after the first enabled cycle following `reset` deassertion. `timer_value` changes on the edge at which `ms_tick` rises.
- Direction change (`up` toggled while `enable`=1): takes effect at the next tick. The prescaler is not cleared.
- Zero/max detection: `at_zero` and `at_max` are combinational from the registered count. The controller's `reset = (timer_value == 0)` feedback therefore sees the new value the cycle after the step.
- No internal FSM beyond the prescaler/counter. States implicit: IDLE (`enable`=0), COUNT_UP, COUNT_DOWN, SATURATED (at bound with `enable`=1).
- All arithmetic unsigned, CW bits. `preload` > MAX_MS (possible when MAX_MS < 2^CW - 1) is clamped to MAX_MS.

Test Plan (CLKS_PER_MS=4, MAX_MS=2047 unless stated):
1. Async reset mid-count:
   - Stimulus: count up to 5, assert `rst` between edges.
   - Response: `timer_value`=0, `at_zero`=1, `overflow`=0 before the next edge.
2. Up count timing:
   - Stimulus: `reset`=1 `up`=1 for 1 cycle, then `enable`=1.
   - Response: `ms_tick` pulses at cycles 4, 8, 12; `timer_value` = 1, 2, 3 on those edges; `ms_tick` never high 2 cycles in a row.
3. Down count to zero:
   - Stimulus: `preload`=3, `reset`=1 `up`=0, then `enable`=1 for 20 cycles.
   - Response: `timer_value` 3→2→1→0 at cycles 4, 8, 12; stays 0; `at_zero`=1 from cycle 12; `overflow`=0.
4. Saturation (MAX_MS=7):
   - Stimulus: `up`=1 `enable`=1 for 40 cycles.
   - Response: `timer_value` reaches 7 at cycle 28 and holds; `at_max`=1; `overflow`=1 after the tick at cycle 32. A later `reset` clears `overflow` and the count.
5. Hold and resume:
   - Stimulus: `enable`=1 for 6 cycles, `enable`=0 for 10, `enable`=1 again.
   - Response: `timer_value`=1 held through the pause; next step to 2 occurs 2 enabled cycles after resume (prescaler kept at 2).
6. `reset`/`enable` collision:
   - Stimulus: `reset`=1 `enable`=1 `up`=0 `preload`=9 on a would-be tick cycle.
   - Response: `timer_value`=9, prescaler=0, no `ms_tick` that cycle.

Source files
------------

// File: rtl/ms_timer.sv
// Millisecond up/down timer: prescales clk to a 1 ms tick and
// counts it up from zero or down from a clamped preload.
module ms_timer #(
  parameter  int MAX_MS      = 2047,
  parameter  int CLKS_PER_MS = 50000,
  localparam int CW          = $clog2(MAX_MS),
  localparam int PW          = $clog2(CLKS_PER_MS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          reset,
  input  logic          up,
  input  logic          enable,
  input  logic [CW-1:0] preload,
  output logic [CW-1:0] timer_value,
  output logic          ms_tick,
  output logic          at_zero,
  output logic          at_max,
  output logic          overflow
);

  localparam logic [CW-1:0] MAX_V  = CW'(MAX_MS);
  localparam logic [PW-1:0] WRAP_V = PW'(CLKS_PER_MS - 1);

  logic [PW-1:0] r_pre;
  logic [CW-1:0] r_cnt;
  logic          r_tick;
  logic          r_ovf;

  logic          w_wrap;
  logic          w_zero;
  logic          w_max;
  logic [CW-1:0] w_load;
  logic [CW-1:0] w_step;
  logic          w_block;

  assign w_wrap = (r_pre == WRAP_V);
  assign w_zero = (r_cnt == '0);
  assign w_max  = (r_cnt == MAX_V);
  assign w_load = (preload > MAX_V) ? MAX_V : preload;

  always_comb begin
    w_step  = r_cnt;
    w_block = 1'b0;
    if (up) begin
      if (w_max) w_block = 1'b1;
      else       w_step  = r_cnt + CW'(1);
    end else if (!w_zero) begin
      w_step = r_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre  <= '0;
      r_cnt  <= '0;
      r_tick <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (reset) begin
      r_pre  <= '0;
      r_tick <= 1'b0;
      r_ovf  <= 1'b0;
      r_cnt  <= up ? '0 : w_load;
    end else if (enable) begin
      if (w_wrap) begin
        r_pre  <= '0;
        r_tick <= 1'b1;
        r_cnt  <= w_step;
        if (w_block) r_ovf <= 1'b1;
      end else begin
        r_pre  <= r_pre + PW'(1);
        r_tick <= 1'b0;
      end
    end else begin
      r_tick <= 1'b0;
    end
  end

  assign timer_value = r_cnt;
  assign ms_tick     = r_tick;
  assign at_zero     = w_zero;
  assign at_max      = w_max;
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_ms_timer.sv
// Directed bench for ms_timer with a 4-cycle tick; a second
// instance with MAX_MS=7 covers saturation and overflow.
module tb_ms_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reset = 1'b0;
  logic        up = 1'b1;
  logic        enable = 1'b0;
  logic [10:0] preload = '0;

  logic [10:0] tv;
  logic        tick, zero, maxf, ovf;
  logic [2:0]  s_tv;
  logic        s_tick, s_zero, s_max, s_ovf;

  int total = 0;
  int pass  = 0;

  always #5 clk = ~clk;

  ms_timer #(.MAX_MS(2047), .CLKS_PER_MS(4)) dut (
    .clk(clk), .rst(rst), .reset(reset), .up(up),
    .enable(enable), .preload(preload),
    .timer_value(tv), .ms_tick(tick), .at_zero(zero),
    .at_max(maxf), .overflow(ovf)
  );

  ms_timer #(.MAX_MS(7), .CLKS_PER_MS(4)) sdut (
    .clk(clk), .rst(rst), .reset(reset), .up(up),
    .enable(enable), .preload(preload[2:0]),
    .timer_value(s_tv), .ms_tick(s_tick), .at_zero(s_zero),
    .at_max(s_max), .overflow(s_ovf)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_clear(input logic dir, input logic [10:0] pl);
    reset = 1'b1; up = dir; enable = 1'b0; preload = pl;
    step(1);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    step(2);
    total++;
    if (tv !== 11'd0)
      $display("FAIL reset_value got %0d want 0", tv);
    else pass++;
    total++;
    if ({zero, maxf, ovf, tick} !== 4'b1000)
      $display("FAIL reset_flags got %b want 1000",
               {zero, maxf, ovf, tick});
    else pass++;
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_async_reset;
    do_clear(1'b1, 11'd0);
    enable = 1'b1;
    step(20);
    total++;
    if (tv !== 11'd5)
      $display("FAIL pre_rst_count got %0d want 5", tv);
    else pass++;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    total++;
    if (tv !== 11'd0 || zero !== 1'b1 || ovf !== 1'b0)
      $display("FAIL async_rst got tv=%0d z=%b o=%b want 0 1 0",
               tv, zero, ovf);
    else pass++;
    enable = 1'b0;
    step(1);
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_up_timing;
    logic [10:0] exp_v;
    logic        exp_t;
    do_clear(1'b1, 11'd0);
    enable = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step(1);
      exp_v = 11'(c / 4);
      exp_t = (c % 4 == 0);
      total++;
      if (tick !== exp_t)
        $display("FAIL up_tick c=%0d got %b want %b", c, tick, exp_t);
      else pass++;
      total++;
      if (tv !== exp_v)
        $display("FAIL up_value c=%0d got %0d want %0d", c, tv, exp_v);
      else pass++;
    end
    enable = 1'b0;
  endtask

  task automatic test_down_zero;
    do_clear(1'b0, 11'd3);
    total++;
    if (tv !== 11'd3)
      $display("FAIL down_load got %0d want 3", tv);
    else pass++;
    enable = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step(1);
      if (c == 4 || c == 8 || c == 12 || c == 20) begin
        total++;
        if (tv !== 11'(c >= 12 ? 0 : 3 - c / 4))
          $display("FAIL down_value c=%0d got %0d", c, tv);
        else pass++;
      end
      if (c == 11 || c == 12) begin
        total++;
        if (zero !== (c == 12))
          $display("FAIL down_zero c=%0d got %b want %b",
                   c, zero, (c == 12));
        else pass++;
      end
    end
    total++;
    if (ovf !== 1'b0)
      $display("FAIL down_ovf got %b want 0", ovf);
    else pass++;
    enable = 1'b0;
  endtask

  task automatic test_saturation;
    do_clear(1'b1, 11'd0);
    enable = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      step(1);
      if (c == 27) begin
        total++;
        if (s_tv !== 3'd6 || s_max !== 1'b0)
          $display("FAIL sat_c27 got %0d max=%b want 6 0", s_tv, s_max);
        else pass++;
      end
      if (c == 28 || c == 31) begin
        total++;
        if (s_tv !== 3'd7 || s_max !== 1'b1 || s_ovf !== 1'b0)
          $display("FAIL sat_reach c=%0d got %0d m=%b o=%b want 7 1 0",
                   c, s_tv, s_max, s_ovf);
        else pass++;
      end
      if (c == 32 || c == 40) begin
        total++;
        if (s_tv !== 3'd7 || s_ovf !== 1'b1)
          $display("FAIL sat_ovf c=%0d got %0d o=%b want 7 1",
                   c, s_tv, s_ovf);
        else pass++;
      end
    end
    do_clear(1'b1, 11'd0);
    total++;
    if (s_tv !== 3'd0 || s_ovf !== 1'b0 || s_max !== 1'b0)
      $display("FAIL sat_clear got %0d o=%b m=%b want 0 0 0",
               s_tv, s_ovf, s_max);
    else pass++;
  endtask

  task automatic test_hold_resume;
    do_clear(1'b1, 11'd0);
    enable = 1'b1;
    step(6);
    enable = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      step(1);
      if (c == 1 || c == 10) begin
        total++;
        if (tv !== 11'd1 || tick !== 1'b0)
          $display("FAIL hold c=%0d got %0d t=%b want 1 0", c, tv, tick);
        else pass++;
      end
    end
    enable = 1'b1;
    step(1);
    total++;
    if (tv !== 11'd1)
      $display("FAIL resume_r1 got %0d want 1", tv);
    else pass++;
    step(1);
    total++;
    if (tv !== 11'd2 || tick !== 1'b1)
      $display("FAIL resume_r2 got %0d t=%b want 2 1", tv, tick);
    else pass++;
    enable = 1'b0;
  endtask

  task automatic test_collision;
    do_clear(1'b1, 11'd0);
    enable = 1'b1;
    step(3);
    reset = 1'b1; up = 1'b0; preload = 11'd9;
    step(1);
    total++;
    if (tv !== 11'd9 || tick !== 1'b0)
      $display("FAIL collide got %0d t=%b want 9 0", tv, tick);
    else pass++;
    reset = 1'b0;
    step(3);
    total++;
    if (tv !== 11'd9 || tick !== 1'b0)
      $display("FAIL collide_pre3 got %0d t=%b want 9 0", tv, tick);
    else pass++;
    step(1);
    total++;
    if (tv !== 11'd8 || tick !== 1'b1)
      $display("FAIL collide_pre4 got %0d t=%b want 8 1", tv, tick);
    else pass++;
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_up_timing();
    test_down_zero();
    test_saturation();
    test_hold_resume();
    test_collision();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
